vga_gc_datapath: RTL and testbench

Parametrised successor to the EGA graphics path. It holds the sequencer map mask and the graphics-controller register file, and runs the CPU-to-VRAM datapath with all four write modes, the ALU, rotate, set/reset, bit mask and both read modes (including colour compare) over `PLANES` bit planes. It sits between the CPU bus decode and a multi-plane VRAM that has configurable read latency, and sequences each access with a small state machine and a busy handshake.

---
 rtl/vga_gc_datapath.sv | 208 ++++++++++++++++++++
 tb/tb_vga_gc_datapath.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_gc_datapath.sv
// Planar VGA graphics-controller datapath: sequencer map mask, GC register file,
// four write modes with ALU/rotate/set-reset/bit mask, and both read modes.
module vga_gc_datapath #(
   parameter int PLANES = 4,
   parameter int ADDR_W = 14,
   parameter int RD_LAT = 1
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic                iIoWr,
   input  logic [11:0]         iIoAddr,
   input  logic [7:0]          iIoData,
   input  logic                iMemWr,
   input  logic                iMemRd,
   input  logic [ADDR_W-1:0]   iAddr,
   input  logic [7:0]          iWrData,
   output logic [7:0]          oRdData,
   output logic                oRdValid,
   output logic                oBusy,
   output logic [ADDR_W-1:0]   oVramAddr,
   output logic                oVramRd,
   input  logic [8*PLANES-1:0] iVramRdData,
   output logic [PLANES-1:0]   oVramWr,
   output logic [8*PLANES-1:0] oVramWrData
);

   localparam int DW   = 8 * PLANES;
   localparam int RM_W = (PLANES > 1) ? $clog2(PLANES) : 1;

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t state, state_next;
   logic [2:0] wait_cnt;
   logic       wait_last;
   logic       accept_wr, accept_rd;

   // Register file
   logic [7:0]        seq_idx, gc_idx;
   logic [PLANES-1:0] map_mask, set_reset, set_reset_en, color_cmp, dont_care;
   logic [2:0]        rot_amt;
   logic [1:0]        alu_func, write_mode;
   logic [RM_W-1:0]   read_map;
   logic              read_mode;
   logic [7:0]        bit_mask;

   // Read context captured at accept, so IO writes cannot disturb an access in flight
   logic              cap_mode;
   logic [RM_W-1:0]   cap_map;
   logic [PLANES-1:0] cap_cmp, cap_dc;

   logic [DW-1:0] latches;
   logic [DW-1:0] wr_next;
   logic [15:0]   rot_wide;
   logic [7:0]    rot_data;
   logic [7:0]    rd_result;

   assign accept_wr = (state == S_IDLE) && iMemWr;
   assign accept_rd = (state == S_IDLE) && iMemRd && !iMemWr;
   assign wait_last = (wait_cnt == 3'(RD_LAT - 1));

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) state <= S_IDLE;
      else      state <= state_next;
   end

   // NOTE: every signal driven from always_comb gets a default first, so no path leaves it unassigned and infers a latch.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (iMemWr) state_next = S_WRITE;
                  else if (iMemRd) state_next = S_ISSUE;
         S_WRITE: state_next = S_IDLE;
         S_ISSUE: state_next = S_WAIT;
         S_WAIT:  if (wait_last) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) wait_cnt <= '0;
      else if (state == S_ISSUE) wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 3'd1;
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         seq_idx      <= '0;
         gc_idx       <= '0;
         map_mask     <= '1;
         set_reset    <= '0;
         set_reset_en <= '0;
         color_cmp    <= '0;
         rot_amt      <= '0;
         alu_func     <= '0;
         read_map     <= '0;
         write_mode   <= '0;
         read_mode    <= 1'b0;
         dont_care    <= '0;
         bit_mask     <= 8'hFF;
      end else if (iIoWr) begin
         case (iIoAddr)
            12'h3C4: seq_idx <= iIoData;
            12'h3C5: if (seq_idx == 8'd2) map_mask <= iIoData[PLANES-1:0];
            12'h3CE: gc_idx <= iIoData;
            12'h3CF: begin
               case (gc_idx)
                  8'd0: set_reset    <= iIoData[PLANES-1:0];
                  8'd1: set_reset_en <= iIoData[PLANES-1:0];
                  8'd2: color_cmp    <= iIoData[PLANES-1:0];
                  8'd3: begin
                     rot_amt  <= iIoData[2:0];
                     alu_func <= iIoData[4:3];
                  end
                  8'd4: read_map <= (int'(iIoData[RM_W-1:0]) < PLANES) ? iIoData[RM_W-1:0] : '0;
                  8'd5: begin
                     write_mode <= iIoData[1:0];
                     read_mode  <= iIoData[3];
                  end
                  8'd7: dont_care <= iIoData[PLANES-1:0];
                  8'd8: bit_mask  <= iIoData;
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign rot_wide = {iWrData, iWrData} >> rot_amt;
   assign rot_data = rot_wide[7:0];

   always_comb begin
      logic [7:0] lat, src, mask, alu;
      wr_next = '0;
      for (int p = 0; p < PLANES; p++) begin
         lat  = latches[8*p +: 8];
         src  = rot_data;
         mask = bit_mask;
         case (write_mode)
            2'd0: if (set_reset_en[p]) src = {8{set_reset[p]}};
            2'd2: src = {8{iWrData[p]}};
            2'd3: begin
               src  = {8{set_reset[p]}};
               mask = rot_data & bit_mask;
            end
            default: ;
         endcase
         case (alu_func)
            2'd1:    alu = src & lat;
            2'd2:    alu = src | lat;
            2'd3:    alu = src ^ lat;
            default: alu = src;
         endcase
         wr_next[8*p +: 8] = (write_mode == 2'd1) ? lat : ((mask & alu) | (~mask & lat));
      end
   end

   always_comb begin
      logic [7:0] plane, sel, diff;
      sel  = '0;
      diff = '0;
      for (int p = 0; p < PLANES; p++) begin
         plane = iVramRdData[8*p +: 8];
         if (cap_map == RM_W'(p)) sel = plane;
         diff = diff | ((plane ^ {8{cap_cmp[p]}}) & {8{cap_dc[p]}});
      end
      rd_result = cap_mode ? ~diff : sel;
   end

   // NOTE: the plane latches are real state visible through write mode 1, so they get a defined reset value.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         latches     <= '0;
         oRdData     <= '0;
         oVramAddr   <= '0;
         oVramWr     <= '0;
         oVramWrData <= '0;
         cap_mode    <= 1'b0;
         cap_map     <= '0;
         cap_cmp     <= '0;
         cap_dc      <= '0;
      end else begin
         oVramWr <= accept_wr ? map_mask : '0;
         if (accept_wr) begin
            oVramAddr   <= iAddr;
            oVramWrData <= wr_next;
         end
         if (accept_rd) begin
            oVramAddr <= iAddr;
            cap_mode  <= read_mode;
            cap_map   <= read_map;
            cap_cmp   <= color_cmp;
            cap_dc    <= dont_care;
         end
         if (state == S_WAIT && wait_last) begin
            latches <= iVramRdData;
            oRdData <= rd_result;
         end
      end
   end

   assign oBusy    = (state != S_IDLE);
   assign oVramRd  = (state == S_ISSUE);
   assign oRdValid = (state == S_DONE);

endmodule

// File: tb/tb_vga_gc_datapath.sv
// Directed self-checking bench for vga_gc_datapath (PLANES=4, RD_LAT=3).
module tb_vga_gc_datapath;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        io_wr_s = 1'b0;
   logic [11:0] io_addr = '0;
   logic [7:0]  io_data = '0;
   logic        mem_wr = 1'b0, mem_rd = 1'b0;
   logic [13:0] addr = '0;
   logic [7:0]  wr_data = '0;
   logic [7:0]  rd_data;
   logic        rd_valid, busy, vram_rd;
   logic [13:0] vram_addr;
   logic [31:0] vram_data = '0;
   logic [3:0]  vram_wr;
   logic [31:0] vram_wr_data;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vga_gc_datapath #(.PLANES(4), .ADDR_W(14), .RD_LAT(3)) dut (
      .iClk(clk), .iRst(rst), .iIoWr(io_wr_s), .iIoAddr(io_addr), .iIoData(io_data),
      .iMemWr(mem_wr), .iMemRd(mem_rd), .iAddr(addr), .iWrData(wr_data),
      .oRdData(rd_data), .oRdValid(rd_valid), .oBusy(busy), .oVramAddr(vram_addr),
      .oVramRd(vram_rd), .iVramRdData(vram_data), .oVramWr(vram_wr), .oVramWrData(vram_wr_data)
   );

   task automatic io_wr(input logic [11:0] a, input logic [7:0] d);
      @(negedge clk); io_wr_s = 1'b1; io_addr = a; io_data = d;
      @(negedge clk); io_wr_s = 1'b0;
   endtask

   task automatic gc_wr(input logic [7:0] idx, input logic [7:0] val);
      io_wr(12'h3CE, idx);
      io_wr(12'h3CF, val);
   endtask

   task automatic seq_wr(input logic [7:0] idx, input logic [7:0] val);
      io_wr(12'h3C4, idx);
      io_wr(12'h3C5, val);
   endtask

   // Returns in cycle N+1 (write accepted in N)
   task automatic mem_write(input logic [13:0] a, input logic [7:0] d);
      @(negedge clk); mem_wr = 1'b1; addr = a; wr_data = d;
      @(negedge clk); mem_wr = 1'b0;
   endtask

   task automatic read_start(input logic [13:0] a);
      @(negedge clk); mem_rd = 1'b1; addr = a;
      @(negedge clk); mem_rd = 1'b0;
   endtask

   // Cycles counted from acceptance; returns in the oRdValid cycle
   task automatic read_finish(output int lat);
      lat = 1;
      while (!rd_valid && lat < 12) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      #3;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0b want=0", rd_valid); end
      checks++; if (vram_wr !== 4'h0) begin failures++; $display("FAIL reset_vram_wr got=%h want=0", vram_wr); end
      checks++; if (vram_rd !== 1'b0) begin failures++; $display("FAIL reset_vram_rd got=%0b want=0", vram_rd); end
      checks++; if (vram_addr !== 14'h0 || rd_data !== 8'h0 || vram_wr_data !== 32'h0) begin
         failures++; $display("FAIL reset_data addr=%h rd=%h wd=%h want all 0", vram_addr, rd_data, vram_wr_data);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_mode0_default;
      mem_write(14'h0123, 8'h5A);
      checks++; if (vram_wr !== 4'hF) begin failures++; $display("FAIL m0_we got=%h want=f", vram_wr); end
      checks++; if (vram_wr_data !== 32'h5A5A5A5A) begin failures++; $display("FAIL m0_data got=%h want=5a5a5a5a", vram_wr_data); end
      checks++; if (vram_addr !== 14'h0123) begin failures++; $display("FAIL m0_addr got=%h want=0123", vram_addr); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL m0_busy got=%0b want=1", busy); end
      @(negedge clk);
      checks++; if (vram_wr !== 4'h0 || busy !== 1'b0) begin
         failures++; $display("FAIL m0_after we=%h busy=%0b want 0/0", vram_wr, busy);
      end
      checks++; if (vram_addr !== 14'h0123) begin failures++; $display("FAIL m0_addr_hold got=%h want=0123", vram_addr); end
   endtask

   task automatic test_mode2_mode1;
      int lat;
      vram_data = 32'h33221100;
      read_start(14'h0200);
      checks++; if (vram_rd !== 1'b1 || vram_addr !== 14'h0200) begin
         failures++; $display("FAIL rd_issue rd=%0b addr=%h want 1/0200", vram_rd, vram_addr);
      end
      read_finish(lat);
      checks++; if (lat != 5) begin failures++; $display("FAIL rd_latency got=%0d want=5", lat); end
      checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL rd_plane0 got=%h want=00", rd_data); end
      gc_wr(8'd8, 8'h0F);
      gc_wr(8'd5, 8'h02);
      mem_write(14'h0010, 8'h05);
      checks++; if (vram_wr_data !== 32'h302F100F) begin failures++; $display("FAIL m2_data got=%h want=302f100f", vram_wr_data); end
      gc_wr(8'd5, 8'h01);
      seq_wr(8'd2, 8'h05);
      mem_write(14'h0011, 8'h77);
      checks++; if (vram_wr_data !== 32'h33221100) begin failures++; $display("FAIL m1_data got=%h want=33221100", vram_wr_data); end
      checks++; if (vram_wr !== 4'h5) begin failures++; $display("FAIL map_mask got=%h want=5", vram_wr); end
      seq_wr(8'd2, 8'h0F);
   endtask

   task automatic test_alu_xor;
      int lat;
      vram_data = 32'hFFFFFFFF;
      gc_wr(8'd5, 8'h00);
      read_start(14'h0300);
      read_finish(lat);
      checks++; if (rd_data !== 8'hFF) begin failures++; $display("FAIL xor_setup_rd got=%h want=ff", rd_data); end
      gc_wr(8'd8, 8'hFF);
      gc_wr(8'd3, 8'h19);
      gc_wr(8'd1, 8'h01);
      gc_wr(8'd0, 8'h00);
      mem_write(14'h0301, 8'h03);
      checks++; if (vram_wr_data !== 32'h7E7E7EFF) begin failures++; $display("FAIL xor_data got=%h want=7e7e7eff", vram_wr_data); end
   endtask

   task automatic test_mode3_rotate;
      gc_wr(8'd3, 8'h07);
      gc_wr(8'd0, 8'h05);
      gc_wr(8'd5, 8'h03);
      mem_write(14'h0302, 8'h03);
      checks++; if (vram_wr_data !== 32'hF9FFF9FF) begin failures++; $display("FAIL m3_rot7 got=%h want=f9fff9ff", vram_wr_data); end
   endtask

   task automatic test_color_compare;
      int lat;
      vram_data = 32'hFF00F00F;
      gc_wr(8'd2, 8'h09);
      gc_wr(8'd7, 8'h0F);
      gc_wr(8'd5, 8'h08);
      read_start(14'h0400);
      read_finish(lat);
      checks++; if (lat != 5) begin failures++; $display("FAIL cc_latency got=%0d want=5", lat); end
      checks++; if (rd_data !== 8'h0F) begin failures++; $display("FAIL cc_all got=%h want=0f", rd_data); end
      gc_wr(8'd7, 8'h08);
      read_start(14'h0401);
      read_finish(lat);
      checks++; if (rd_data !== 8'hFF) begin failures++; $display("FAIL cc_plane3 got=%h want=ff", rd_data); end
   endtask

   task automatic test_busy;
      int lat;
      logic saw_wr;
      gc_wr(8'd5, 8'h00);
      gc_wr(8'd3, 8'h00);
      gc_wr(8'd4, 8'h00);
      vram_data = 32'hA1B2C3D4;
      read_start(14'h0500);
      @(negedge clk); mem_wr = 1'b1; wr_data = 8'h99; io_wr_s = 1'b1; io_addr = 12'h3CF; io_data = 8'h03;
      @(negedge clk); mem_wr = 1'b0; io_wr_s = 1'b0;
      saw_wr = (vram_wr != 4'h0);
      lat = 0;
      while (!rd_valid && lat < 12) begin
         @(negedge clk);
         saw_wr = saw_wr | (vram_wr != 4'h0);
         lat++;
      end
      checks++; if (saw_wr !== 1'b0) begin failures++; $display("FAIL busy_drop write seen=%0b want=0", saw_wr); end
      checks++; if (rd_data !== 8'hD4) begin failures++; $display("FAIL busy_captured_map got=%h want=d4", rd_data); end
      read_start(14'h0501);
      read_finish(lat);
      checks++; if (rd_data !== 8'hA1) begin failures++; $display("FAIL busy_new_map got=%h want=a1", rd_data); end
      @(negedge clk); mem_wr = 1'b1; mem_rd = 1'b1; addr = 14'h0502; wr_data = 8'h3C;
      @(negedge clk); mem_wr = 1'b0; mem_rd = 1'b0;
      checks++; if (vram_wr !== 4'hF || vram_rd !== 1'b0) begin
         failures++; $display("FAIL simul_n1 we=%h rd=%0b want f/0", vram_wr, vram_rd);
      end
      checks++; if (vram_wr_data !== 32'h3C3C3CFF) begin failures++; $display("FAIL simul_data got=%h want=3c3c3cff", vram_wr_data); end
      @(negedge clk);
      checks++; if (vram_rd !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL simul_n2 rd=%0b busy=%0b want 0/0", vram_rd, busy);
      end
   endtask

   task automatic test_reset_mid;
      logic saw_valid;
      seq_wr(8'd2, 8'h03);
      read_start(14'h0600);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || vram_rd !== 1'b0 || rd_valid !== 1'b0 || vram_wr !== 4'h0) begin
         failures++; $display("FAIL midrst_ctrl busy=%0b rd=%0b valid=%0b we=%h want 0", busy, vram_rd, rd_valid, vram_wr);
      end
      checks++; if (vram_addr !== 14'h0 || rd_data !== 8'h0 || vram_wr_data !== 32'h0) begin
         failures++; $display("FAIL midrst_data addr=%h rd=%h wd=%h want 0", vram_addr, rd_data, vram_wr_data);
      end
      @(negedge clk); rst = 1'b0;
      saw_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         saw_valid = saw_valid | rd_valid;
      end
      checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_valid seen=%0b want=0", saw_valid); end
      mem_write(14'h0005, 8'h11);
      checks++; if (vram_wr !== 4'hF) begin failures++; $display("FAIL midrst_mapmask got=%h want=f", vram_wr); end
      checks++; if (vram_wr_data !== 32'h11111111 || vram_addr !== 14'h0005) begin
         failures++; $display("FAIL midrst_write wd=%h addr=%h want 11111111/0005", vram_wr_data, vram_addr);
      end
   endtask

   initial begin
      test_reset();
      test_mode0_default();
      test_mode2_mode1();
      test_alu_xor();
      test_mode3_rotate();
      test_color_compare();
      test_busy();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
